control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcode step sequencer for the 16-bit CPU.
- Sits directly upstream of the common registers (A, B, IR, MAR, PC, OUT). It generates their load enables, the RAM write strobe and the shared-bus source select.
- Inputs are the IR contents and the ALU flags.
- Runs a fixed fetch phase (T0-T1), then an opcode-dependent execute phase (T2-T4), then returns to T0.

Parameters:
- DATA_WIDTH, 16, instruction/bus width (from CPU_package).
- OPC_WIDTH, 4, opcode field width; opcode = iinstr[DATA_WIDTH-1 -: OPC_WIDTH].
- STEP_WIDTH, 3, step counter width.

Ports:
- iclk  input  1  clock.
- irst_n  input  1  asynchronous active-low reset.
- iinstr  input  DATA_WIDTH  current IR odata.
- iflag_carry  input  1  ALU carry flag register output.
- iflag_zero  input  1  ALU zero flag register output.
- omar_en  output  1  MAR load enable.
- oir_en  output  1  IR load enable.
- oa_en  output  1  A load enable.
- ob_en  output  1  B load enable.
- oout_en  output  1  OUT load enable.
- opc_inc  output  1  PC increment.
- opc_load  output  1  PC load from bus.
- oram_we  output  1  RAM write strobe.
- oalu_sub  output  1  ALU subtract select.
- obus_sel  output  3  bus source (bus_sel_t).
- ostep  output  STEP_WIDTH  current step.
- ohalted  output  1  halt status.

Behaviour:
- Reset (asynchronous, irst_n low):
  - step=T0, halted=0.
  - All control outputs are forced 0 and obus_sel=BUS_NONE, combinationally gated while irst_n is low.
  - Reset mid-instruction abandons the instruction; no partial strobe is emitted.
- State: registered step (T0..T4) and halted flag. The control word is a combinational decode of (step, opcode, flags). Each enable is valid for the whole step cycle and is consumed by the registers on the rising edge that ends the step.
- Fetch:
  - T0: obus_sel=PC, omar_en.
  - T1: obus_sel=RAM, oir_en, opc_inc.
  - iinstr is valid from T2 onward.
- Execute ("last" marks the step after which the counter returns to T0 on the next edge):
  - NOP 0x0: T2 no strobes, last.
  - LDA 0x1: T2 bus=IR_OPND, mar_en. T3 bus=RAM, a_en, last.
  - ADD 0x2: T2 bus=IR_OPND, mar_en. T3 bus=RAM, b_en. T4 bus=ALU, a_en, last.
  - SUB 0x3: as ADD, with oalu_sub=1 in T3 and T4.
  - STA 0x4: T2 bus=IR_OPND, mar_en. T3 bus=A, ram_we, last.
  - LDI 0x5: T2 bus=IR_OPND, a_en, last.
  - JMP 0x6: T2 bus=IR_OPND, pc_load, last.
  - OUT 0xE: T2 bus=A, out_en, last.
  - HLT 0xF: T2 no strobes; halted is set on the edge ending T2. Step freezes at T2 and all strobes stay 0 until reset; ohalted=1.
  - Any undefined opcode executes as NOP.
- Bus-select rule: obus_sel=BUS_NONE whenever no step drives the bus.
- Enable exclusivity: at most one bus driver per cycle. opc_inc and opc_load are never both 1.
- Step counter: never exceeds T4. If it reaches T4, it always wraps to T0.
- Flags are sampled combinationally in T2 only.

Optional Feature:
- Macro: CONDJMP_EN.
- Defined:
  - JC 0x7: T2 pc_load with bus=IR_OPND if iflag_carry=1, last.
  - JZ 0x8: T2 pc_load with bus=IR_OPND if iflag_zero=1, last.
  - If the condition is false, T2 has no strobes and the instruction ends.
- Undefined: 0x7 and 0x8 decode as NOP; flag inputs remain ports but are unused.

Decomposition:
- CPU_package gains:
  - opcode_t enum (OPC_NOP..OPC_HLT, OPC_JC, OPC_JZ).
  - step_t enum (T0..T4).
  - bus_sel_t enum: BUS_NONE=0, BUS_PC=1, BUS_RAM=2, BUS_IR_OPND=3, BUS_A=4, BUS_ALU=5.
  - ctrl_word_t packed struct of all strobes.
  - OPC_WIDTH and STEP_WIDTH.
- One natural sub-module, microcode_decoder: purely combinational (step, opcode, flags) -> ctrl_word_t plus a "last" bit. The sequencer holds only the step/halt registers and the reset gating.

Test Plan:
- Reset then release, iinstr=0x0000 -> cycle1 omar_en=1, obus_sel=1; cycle2 oir_en=1, opc_inc=1, obus_sel=2; cycle3 no strobes; cycle4 ostep=T0.
- iinstr=0x2010 (ADD 0x010) -> T2 omar_en with bus=3; T3 ob_en with bus=2, oalu_sub=0; T4 oa_en with bus=5; next ostep=0.
- iinstr=0x4005 (STA) -> T3 oram_we=1 with bus=4; no oa_en/ob_en asserted in any step.
- iinstr=0xF000 -> ohalted=1 after T2; ostep holds at 2 and all strobes stay 0 for 20 cycles; irst_n pulse -> ohalted=0, ostep=0.
- CONDJMP_EN defined, iinstr=0x7123: iflag_carry=1 -> T2 opc_load=1, bus=3; iflag_carry=0 -> no opc_load. CONDJMP_EN undefined -> never opc_load.
- Assert irst_n low during T3 of SUB -> all outputs 0 immediately; after release the sequencer restarts at T0 fetch.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types for the microcode step sequencer: opcodes, steps, bus sources and the control word.
// Conditional jumps (JC/JZ) are decoded only when CONDJMP_EN is defined.
package control_sequencer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int OPC_WIDTH  = 4;
    localparam int STEP_WIDTH = 3;

    typedef enum logic [OPC_WIDTH-1:0] {
        OPC_NOP = 4'h0,
        OPC_LDA = 4'h1,
        OPC_ADD = 4'h2,
        OPC_SUB = 4'h3,
        OPC_STA = 4'h4,
        OPC_LDI = 4'h5,
        OPC_JMP = 4'h6,
        OPC_JC  = 4'h7,
        OPC_JZ  = 4'h8,
        OPC_OUT = 4'hE,
        OPC_HLT = 4'hF
    } opcode_t;

    typedef enum logic [STEP_WIDTH-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef enum logic [2:0] {
        BUS_NONE    = 3'd0,
        BUS_PC      = 3'd1,
        BUS_RAM     = 3'd2,
        BUS_IR_OPND = 3'd3,
        BUS_A       = 3'd4,
        BUS_ALU     = 3'd5
    } bus_sel_t;

    typedef struct packed {
        logic     mar_en;
        logic     ir_en;
        logic     a_en;
        logic     b_en;
        logic     out_en;
        logic     pc_inc;
        logic     pc_load;
        logic     ram_we;
        logic     alu_sub;
        bus_sel_t bus_sel;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        mar_en: 1'b0, ir_en: 1'b0, a_en: 1'b0, b_en: 1'b0, out_en: 1'b0,
        pc_inc: 1'b0, pc_load: 1'b0, ram_we: 1'b0, alu_sub: 1'b0,
        bus_sel: BUS_NONE
    };

endpackage

// File: rtl/control_sequencer_microcode_decoder.sv
// Combinational microcode ROM: (step, opcode, flags) -> control word, end-of-instruction and halt request.
// JC/JZ are decoded only when CONDJMP_EN is defined; otherwise they fall through to NOP.
module microcode_decoder
    import control_sequencer_pkg::*;
(
    input  step_t                step,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 flag_carry,
    input  logic                 flag_zero,
    output ctrl_word_t           ctrl,
    output logic                 last,
    output logic                 halt
);

`ifndef CONDJMP_EN
    logic unused_flags_s;
    assign unused_flags_s = flag_carry ^ flag_zero;
`endif

    // Decode one microcode step; unknown steps/opcodes end the instruction with no strobes.
    always_comb begin
        ctrl = CTRL_IDLE;
        last = 1'b0;
        halt = 1'b0;
        case (step)
            T0: begin
                ctrl.bus_sel = BUS_PC;
                ctrl.mar_en  = 1'b1;
            end
            T1: begin
                ctrl.bus_sel = BUS_RAM;
                ctrl.ir_en   = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OPC_LDA, OPC_ADD, OPC_SUB, OPC_STA: begin
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.mar_en  = 1'b1;
                    end
                    OPC_LDI: begin
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.a_en    = 1'b1;
                        last         = 1'b1;
                    end
                    OPC_JMP: begin
                        ctrl.bus_sel = BUS_IR_OPND;
                        ctrl.pc_load = 1'b1;
                        last         = 1'b1;
                    end
                    OPC_OUT: begin
                        ctrl.bus_sel = BUS_A;
                        ctrl.out_en  = 1'b1;
                        last         = 1'b1;
                    end
                    OPC_HLT: begin
                        halt = 1'b1;
                    end
`ifdef CONDJMP_EN
                    OPC_JC, OPC_JZ: begin
                        if ((opcode == OPC_JC) ? flag_carry : flag_zero) begin
                            ctrl.bus_sel = BUS_IR_OPND;
                            ctrl.pc_load = 1'b1;
                        end else begin
                            ctrl = CTRL_IDLE;
                        end
                        last = 1'b1;
                    end
`endif
                    default: begin
                        last = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OPC_LDA: begin
                        ctrl.bus_sel = BUS_RAM;
                        ctrl.a_en    = 1'b1;
                        last         = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        ctrl.bus_sel = BUS_RAM;
                        ctrl.b_en    = 1'b1;
                        ctrl.alu_sub = (opcode == OPC_SUB);
                    end
                    OPC_STA: begin
                        ctrl.bus_sel = BUS_A;
                        ctrl.ram_we  = 1'b1;
                        last         = 1'b1;
                    end
                    default: begin
                        last = 1'b1;
                    end
                endcase
            end
            T4: begin
                case (opcode)
                    OPC_ADD, OPC_SUB: begin
                        ctrl.bus_sel = BUS_ALU;
                        ctrl.a_en    = 1'b1;
                        ctrl.alu_sub = (opcode == OPC_SUB);
                    end
                    default: begin
                        ctrl = CTRL_IDLE;
                    end
                endcase
                last = 1'b1;
            end
            default: begin
                last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Step/halt registers plus reset and halt gating around the microcode decoder.
// Build with CONDJMP_EN defined to enable the JC/JZ conditional jumps.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [DATA_WIDTH-1:0] iinstr,
    input  logic                  iflag_carry,
    input  logic                  iflag_zero,
    output logic                  omar_en,
    output logic                  oir_en,
    output logic                  oa_en,
    output logic                  ob_en,
    output logic                  oout_en,
    output logic                  opc_inc,
    output logic                  opc_load,
    output logic                  oram_we,
    output logic                  oalu_sub,
    output logic [2:0]            obus_sel,
    output logic [STEP_WIDTH-1:0] ostep,
    output logic                  ohalted
);

    step_t      step_r;
    logic       halted_r;
    ctrl_word_t ctrl_s;
    ctrl_word_t ctrl_out_s;
    logic       last_s;
    logic       halt_s;
    logic       unused_operand_s;

    assign unused_operand_s = ^iinstr[DATA_WIDTH-OPC_WIDTH-1:0];

    microcode_decoder u_decoder (
        .step       (step_r),
        .opcode     (iinstr[DATA_WIDTH-1 -: OPC_WIDTH]),
        .flag_carry (iflag_carry),
        .flag_zero  (iflag_zero),
        .ctrl       (ctrl_s),
        .last       (last_s),
        .halt       (halt_s)
    );

    // Advance the step counter; a halt freezes it at T2 until reset.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            step_r   <= T0;
            halted_r <= 1'b0;
        end else if (halted_r) begin
            step_r   <= step_r;
            halted_r <= 1'b1;
        end else if (halt_s) begin
            step_r   <= step_r;
            halted_r <= 1'b1;
        end else if (last_s) begin
            step_r   <= T0;
        end else begin
            step_r   <= step_t'(step_r + 3'd1);
        end
    end

    // Reset must kill strobes immediately, not at the next edge, so gate combinationally.
    always_comb begin
        ctrl_out_s = CTRL_IDLE;
        if (irst_n && !halted_r) begin
            ctrl_out_s = ctrl_s;
        end else begin
            ctrl_out_s = CTRL_IDLE;
        end
    end

    assign omar_en  = ctrl_out_s.mar_en;
    assign oir_en   = ctrl_out_s.ir_en;
    assign oa_en    = ctrl_out_s.a_en;
    assign ob_en    = ctrl_out_s.b_en;
    assign oout_en  = ctrl_out_s.out_en;
    assign opc_inc  = ctrl_out_s.pc_inc;
    assign opc_load = ctrl_out_s.pc_load;
    assign oram_we  = ctrl_out_s.ram_we;
    assign oalu_sub = ctrl_out_s.alu_sub;
    assign obus_sel = ctrl_out_s.bus_sel;
    assign ostep    = step_r;
    assign ohalted  = halted_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; expectations follow CONDJMP_EN when defined.
module tb_control_sequencer;

    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_MAR  = 9'b100000000;
    localparam logic [8:0] E_IR   = 9'b010000000;
    localparam logic [8:0] E_A    = 9'b001000000;
    localparam logic [8:0] E_B    = 9'b000100000;
    localparam logic [8:0] E_OUT  = 9'b000010000;
    localparam logic [8:0] E_INC  = 9'b000001000;
    localparam logic [8:0] E_LOAD = 9'b000000100;
    localparam logic [8:0] E_WE   = 9'b000000010;
    localparam logic [8:0] E_SUB  = 9'b000000001;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic [15:0] iinstr = 16'h0000;
    logic        iflag_carry = 1'b0;
    logic        iflag_zero = 1'b0;
    logic        omar_en, oir_en, oa_en, ob_en, oout_en;
    logic        opc_inc, opc_load, oram_we, oalu_sub;
    logic [2:0]  obus_sel;
    logic [2:0]  ostep;
    logic        ohalted;
    logic [11:0] obs_w;

    int n_tests = 0;
    int n_fail  = 0;

    control_sequencer dut (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .iinstr      (iinstr),
        .iflag_carry (iflag_carry),
        .iflag_zero  (iflag_zero),
        .omar_en     (omar_en),
        .oir_en      (oir_en),
        .oa_en       (oa_en),
        .ob_en       (ob_en),
        .oout_en     (oout_en),
        .opc_inc     (opc_inc),
        .opc_load    (opc_load),
        .oram_we     (oram_we),
        .oalu_sub    (oalu_sub),
        .obus_sel    (obus_sel),
        .ostep       (ostep),
        .ohalted     (ohalted)
    );

    always #5 iclk = ~iclk;

    assign obs_w = {omar_en, oir_en, oa_en, ob_en, oout_en,
                    opc_inc, opc_load, oram_we, oalu_sub, obus_sel};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the current step and control word, then move to the middle of the next cycle.
    task automatic step_chk(input string tag, input logic [2:0] st, input logic [8:0] en, input logic [2:0] bus);
        check_eq($sformatf("%s_step", tag), {29'd0, ostep}, {29'd0, st});
        check_eq($sformatf("%s_ctrl", tag), {20'd0, obs_w}, {20'd0, en, bus});
        @(negedge iclk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step_chk($sformatf("%s_t0", tag), 3'd0, E_MAR, 3'd1);
        step_chk($sformatf("%s_t1", tag), 3'd1, E_IR | E_INC, 3'd2);
    endtask

    task automatic do_reset();
        irst_n = 1'b0;
        #1;
        check_eq("rst_ctrl", {20'd0, obs_w}, 32'd0);
        check_eq("rst_step", {29'd0, ostep}, 32'd0);
        check_eq("rst_halt", {31'd0, ohalted}, 32'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        #1;
    endtask

    initial begin
        @(negedge iclk);
        do_reset();

        // NOP: fetch, one empty execute step, back to T0
        iinstr = 16'h0000;
        fetch("nop");
        step_chk("nop_t2", 3'd2, E_NONE, 3'd0);

        iinstr = 16'h2010;
        fetch("add");
        step_chk("add_t2", 3'd2, E_MAR, 3'd3);
        step_chk("add_t3", 3'd3, E_B, 3'd2);
        step_chk("add_t4", 3'd4, E_A, 3'd5);

        iinstr = 16'h4005;
        fetch("sta");
        step_chk("sta_t2", 3'd2, E_MAR, 3'd3);
        step_chk("sta_t3", 3'd3, E_WE, 3'd4);

        iinstr = 16'h1020;
        fetch("lda");
        step_chk("lda_t2", 3'd2, E_MAR, 3'd3);
        step_chk("lda_t3", 3'd3, E_A, 3'd2);

        iinstr = 16'h5007;
        fetch("ldi");
        step_chk("ldi_t2", 3'd2, E_A, 3'd3);

        iinstr = 16'h6003;
        fetch("jmp");
        step_chk("jmp_t2", 3'd2, E_LOAD, 3'd3);

        iinstr = 16'hE000;
        fetch("out");
        step_chk("out_t2", 3'd2, E_OUT, 3'd4);

        iinstr = 16'hA123;
        fetch("undef");
        step_chk("undef_t2", 3'd2, E_NONE, 3'd0);

        iinstr = 16'h7123;
        iflag_carry = 1'b1;
        fetch("jc1");
`ifdef CONDJMP_EN
        step_chk("jc1_t2", 3'd2, E_LOAD, 3'd3);
`else
        step_chk("jc1_t2", 3'd2, E_NONE, 3'd0);
`endif
        iflag_carry = 1'b0;
        fetch("jc0");
        step_chk("jc0_t2", 3'd2, E_NONE, 3'd0);

        iinstr = 16'h8040;
        iflag_zero = 1'b1;
        iflag_carry = 1'b1;
        fetch("jz1");
`ifdef CONDJMP_EN
        step_chk("jz1_t2", 3'd2, E_LOAD, 3'd3);
`else
        step_chk("jz1_t2", 3'd2, E_NONE, 3'd0);
`endif
        iflag_zero = 1'b0;
        fetch("jz0");
        step_chk("jz0_t2", 3'd2, E_NONE, 3'd0);
        iflag_carry = 1'b0;

        // SUB, then reset in the middle of T3
        iinstr = 16'h3010;
        fetch("sub");
        step_chk("sub_t2", 3'd2, E_MAR, 3'd3);
        check_eq("sub_t3_step", {29'd0, ostep}, 32'd3);
        check_eq("sub_t3_ctrl", {20'd0, obs_w}, {20'd0, E_B | E_SUB, 3'd2});
        irst_n = 1'b0;
        #1;
        check_eq("midrst_ctrl", {20'd0, obs_w}, 32'd0);
        check_eq("midrst_step", {29'd0, ostep}, 32'd0);
        @(negedge iclk);
        check_eq("midrst_hold", {20'd0, obs_w}, 32'd0);
        irst_n = 1'b1;
        #1;
        fetch("restart");
        step_chk("restart_t2", 3'd2, E_MAR, 3'd3);
        step_chk("restart_t3", 3'd3, E_B | E_SUB, 3'd2);
        step_chk("restart_t4", 3'd4, E_A | E_SUB, 3'd5);

        // HLT freezes at T2 with all strobes off until reset
        iinstr = 16'hF000;
        fetch("hlt");
        check_eq("hlt_t2_halt", {31'd0, ohalted}, 32'd0);
        step_chk("hlt_t2", 3'd2, E_NONE, 3'd0);
        for (int i = 0; i < 20; i++) begin
            check_eq($sformatf("hlt_flag%0d", i), {31'd0, ohalted}, 32'd1);
            step_chk($sformatf("hlt_hold%0d", i), 3'd2, E_NONE, 3'd0);
        end
        do_reset();
        iinstr = 16'h0000;
        fetch("post_hlt");
        step_chk("post_hlt_t2", 3'd2, E_NONE, 3'd0);
        check_eq("post_hlt_wrap", {29'd0, ostep}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
